// File: rtl/exec_stage_mc_pkg.sv
// rtl/exec_stage_mc_pkg.sv - shared widths, ALU op codes and execute-stage state encodings
package exec_stage_mc_pkg;
  localparam int DEF_REG_SIZE    = 32;
  localparam int DEF_ADDR_SIZE   = 32;
  localparam int DEF_REG_ADDR    = 5;
  localparam int DEF_MUL_LATENCY = 4;

  typedef enum logic [4:0] {
    ALUOP_ADD  = 5'd0,
    ALUOP_SUB  = 5'd1,
    ALUOP_AND  = 5'd2,
    ALUOP_OR   = 5'd3,
    ALUOP_XOR  = 5'd4,
    ALUOP_SLL  = 5'd5,
    ALUOP_SRL  = 5'd6,
    ALUOP_SRA  = 5'd7,
    ALUOP_SLT  = 5'd8,
    ALUOP_SLTU = 5'd9,
    ALUOP_MUL  = 5'd10
  } aluop_e;

  typedef enum logic [1:0] {
    EXS_IDLE = 2'd0,
    EXS_BUSY = 2'd1,
    EXS_DONE = 2'd2
  } exs_state_e;
endpackage

// File: rtl/exec_stage_mc_alu.sv
// rtl/exec_stage_mc_alu.sv - single-cycle ALU; overflow only meaningful for signed ADD/SUB
module exec_stage_mc_alu
  import exec_stage_mc_pkg::*;
#(
  parameter int W = DEF_REG_SIZE
) (
  input  logic [4:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         zero_o,
  output logic         overflow_o
);
  localparam int SHW = $clog2(W);

  logic [SHW-1:0] shamt;
  logic [W-1:0]   sum;
  logic [W-1:0]   diff;

  assign shamt = b_i[SHW-1:0];
  assign sum   = a_i + b_i;
  assign diff  = a_i - b_i;

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      ALUOP_ADD: begin
        result_o   = sum;
        overflow_o = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      ALUOP_SUB: begin
        result_o   = diff;
        overflow_o = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
      end
      ALUOP_AND:  result_o = a_i & b_i;
      ALUOP_OR:   result_o = a_i | b_i;
      ALUOP_XOR:  result_o = a_i ^ b_i;
      ALUOP_SLL:  result_o = a_i << shamt;
      ALUOP_SRL:  result_o = a_i >> shamt;
      ALUOP_SRA:  result_o = $signed(a_i) >>> shamt;
      ALUOP_SLT:  result_o = {{(W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALUOP_SLTU: result_o = {{(W-1){1'b0}}, a_i < b_i};
      default:    result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/exec_stage_mc_mul_pipe.sv
// rtl/exec_stage_mc_mul_pipe.sv - multi-cycle signed multiplier: operand latch, countdown, product
module exec_stage_mc_mul_pipe
  import exec_stage_mc_pkg::*;
#(
  parameter int W   = DEF_REG_SIZE,
  parameter int LAT = DEF_MUL_LATENCY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] result_o,
  output logic         overflow_o
);
  localparam int CW = (LAT > 2) ? $clog2(LAT - 1) : 1;

  if (LAT < 2) begin : g_lat_check
    $error("MUL_LATENCY must be at least 2");
  end

  exs_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [2*W-1:0]   a_ext;
  logic [2*W-1:0]   b_ext;
  logic [2*W-1:0]   prod;
  logic             cnt_zero;

  assign a_ext      = {{W{a_q[W-1]}}, a_q};
  assign b_ext      = {{W{b_q[W-1]}}, b_q};
  assign prod       = a_ext * b_ext;
  assign result_o   = prod[W-1:0];
  // Product fits in W bits only if the upper half is pure sign extension.
  assign overflow_o = prod[2*W-1:W] != {W{prod[W-1]}};
  assign cnt_zero   = (cnt_q == '0);
  assign busy_o     = (state_q != EXS_IDLE);
  assign done_o     = !flush_i && !stall_i &&
                      (((state_q == EXS_BUSY) && cnt_zero) || (state_q == EXS_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EXS_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (flush_i) begin
      state_q <= EXS_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        EXS_IDLE: if (start_i) begin
          a_q     <= a_i;
          b_q     <= b_i;
          cnt_q   <= CW'(LAT - 2);
          state_q <= EXS_BUSY;
        end
        EXS_BUSY: begin
          if (cnt_zero) state_q <= stall_i ? EXS_DONE : EXS_IDLE;
          else          cnt_q   <= cnt_q - 1'b1;
        end
        EXS_DONE: if (!stall_i) state_q <= EXS_IDLE;
        default:  state_q <= EXS_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/exec_stage_mc.sv
// rtl/exec_stage_mc.sv - multi-cycle execute stage: 1-cycle ALU ops, multi-cycle MUL, branch adder
module exec_stage_mc
  import exec_stage_mc_pkg::*;
#(
  parameter int REG_SIZE    = DEF_REG_SIZE,
  parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int REG_ADDR    = DEF_REG_ADDR,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic                 regwrite_in,
  input  logic                 alusrc,
  input  logic [4:0]           aluop,
  input  logic [REG_SIZE-1:0]  src1,
  input  logic [REG_SIZE-1:0]  reg2,
  input  logic [REG_SIZE-1:0]  immediat,
  input  logic [ADDR_SIZE-1:0] old_pc,
  input  logic [REG_ADDR-1:0]  wreg_in,
  input  logic                 stall_in,
  input  logic                 flush,
  output logic                 stall_out,
  output logic                 valid_out,
  output logic                 regwrite_out,
  output logic                 zero,
  output logic                 overflow,
  output logic [REG_SIZE-1:0]  aluresult,
  output logic [ADDR_SIZE-1:0] pc_branch,
  output logic [REG_ADDR-1:0]  wreg_out
);
  logic [REG_SIZE-1:0]  operand2;
  logic [ADDR_SIZE-1:0] branch_target;
  logic [REG_SIZE-1:0]  alu_result;
  logic                 alu_zero;
  logic                 alu_ovf;
  logic                 is_mul;
  logic                 mul_start;
  logic                 mul_busy;
  logic                 mul_done;
  logic [REG_SIZE-1:0]  mul_result;
  logic                 mul_ovf;

  logic                 valid_q, rw_q, zero_q, ovf_q;
  logic [REG_SIZE-1:0]  res_q;
  logic [ADDR_SIZE-1:0] pc_q, mpc_q;
  logic [REG_ADDR-1:0]  wreg_q, mwreg_q;
  logic                 mrw_q;

  assign operand2      = alusrc ? reg2 : immediat;
  assign branch_target = old_pc + ADDR_SIZE'({immediat, 2'b00});
  assign is_mul        = (aluop == ALUOP_MUL);
  assign stall_out     = mul_busy | stall_in;
  assign mul_start     = valid_in && is_mul && !stall_out && !flush;

  exec_stage_mc_alu #(.W(REG_SIZE)) u_alu (
    .op_i(aluop), .a_i(src1), .b_i(operand2),
    .result_o(alu_result), .zero_o(alu_zero), .overflow_o(alu_ovf)
  );

  exec_stage_mc_mul_pipe #(.W(REG_SIZE), .LAT(MUL_LATENCY)) u_mul (
    .clk(clk), .rst(rst), .start_i(mul_start), .stall_i(stall_in), .flush_i(flush),
    .a_i(src1), .b_i(operand2), .busy_o(mul_busy), .done_o(mul_done),
    .result_o(mul_result), .overflow_o(mul_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0; rw_q <= 1'b0; zero_q <= 1'b0; ovf_q <= 1'b0;
      res_q   <= '0;   pc_q <= '0;   wreg_q <= '0;
      mpc_q   <= '0;   mwreg_q <= '0; mrw_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
    end else if (mul_done) begin
      valid_q <= 1'b1;
      rw_q    <= mrw_q;
      res_q   <= mul_result;
      zero_q  <= (mul_result == '0);
      ovf_q   <= mul_ovf;
      pc_q    <= mpc_q;
      wreg_q  <= mwreg_q;
    end else if (!stall_out) begin
      if (valid_in && is_mul) begin
        // Accepting a MUL retires nothing this edge; side info waits for the product.
        valid_q <= 1'b0;
        rw_q    <= 1'b0;
        mpc_q   <= branch_target;
        mwreg_q <= wreg_in;
        mrw_q   <= regwrite_in;
      end else if (valid_in) begin
        valid_q <= 1'b1;
        rw_q    <= regwrite_in;
        res_q   <= alu_result;
        zero_q  <= alu_zero;
        ovf_q   <= alu_ovf;
        pc_q    <= branch_target;
        wreg_q  <= wreg_in;
      end else begin
        valid_q <= 1'b0;
        rw_q    <= 1'b0;
      end
    end
  end

  assign valid_out    = valid_q;
  assign regwrite_out = rw_q;
  assign zero         = zero_q;
  assign overflow     = ovf_q;
  assign aluresult    = res_q;
  assign pc_branch    = pc_q;
  assign wreg_out     = wreg_q;
endmodule

// File: tb/tb_exec_stage_mc.sv
// tb/tb_exec_stage_mc.sv - self-checking bench for exec_stage_mc with a reference model
module tb_exec_stage_mc;
  import exec_stage_mc_pkg::*;

  typedef struct packed {
    logic        ovf;
    logic        zero;
    logic [31:0] res;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst, valid_in, regwrite_in, alusrc, stall_in, flush;
  logic [4:0]  aluop, wreg_in;
  logic [31:0] src1, reg2, immediat, old_pc;
  logic        stall_out, valid_out, regwrite_out, zero, overflow;
  logic [31:0] aluresult, pc_branch;
  logic [4:0]  wreg_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exec_stage_mc dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .regwrite_in(regwrite_in),
    .alusrc(alusrc), .aluop(aluop), .src1(src1), .reg2(reg2), .immediat(immediat),
    .old_pc(old_pc), .wreg_in(wreg_in), .stall_in(stall_in), .flush(flush),
    .stall_out(stall_out), .valid_out(valid_out), .regwrite_out(regwrite_out),
    .zero(zero), .overflow(overflow), .aluresult(aluresult), .pc_branch(pc_branch),
    .wreg_out(wreg_out)
  );

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint s;
    e = '0;
    case (op)
      ALUOP_ADD: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.res = s[31:0]; e.ovf = (s > SMAX) || (s < SMIN);
      end
      ALUOP_SUB: begin
        s = longint'($signed(a)) - longint'($signed(b));
        e.res = s[31:0]; e.ovf = (s > SMAX) || (s < SMIN);
      end
      ALUOP_AND:  e.res = a & b;
      ALUOP_OR:   e.res = a | b;
      ALUOP_XOR:  e.res = a ^ b;
      ALUOP_SLL:  e.res = a << b[4:0];
      ALUOP_SRL:  e.res = a >> b[4:0];
      ALUOP_SRA:  e.res = $signed(a) >>> b[4:0];
      ALUOP_SLT:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALUOP_SLTU: e.res = (a < b) ? 32'd1 : 32'd0;
      ALUOP_MUL: begin
        s = longint'($signed(a)) * longint'($signed(b));
        e.res = s[31:0];
        e.ovf = (s > SMAX) || (s < SMIN);
      end
      default: e.res = 32'd0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] model_pc(input logic [31:0] pc, input logic [31:0] imm);
    longint t;
    t = longint'(pc) + 4 * longint'($signed(imm));
    return t[31:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] r2, input logic [31:0] imm, input logic as,
                       input logic [31:0] pc, input logic [4:0] wr, input logic rw);
    valid_in = v; aluop = op; src1 = a; reg2 = r2; immediat = imm;
    alusrc = as; old_pc = pc; wreg_in = wr; regwrite_in = rw;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    drive(1'b0, ALUOP_ADD, 0, 0, 0, 1'b0, 0, 0, 1'b0);
    tick; tick;
    n_tests++;
    if ({valid_out, regwrite_out, zero, overflow, aluresult, pc_branch, wreg_out, stall_out} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b rw=%b res=%h pc=%h so=%b expected all 0",
                         valid_out, regwrite_out, aluresult, pc_branch, stall_out);
    end
    rst = 1'b0;
    drive(1'b1, ALUOP_MUL, 32'd7, 0, 32'd9, 1'b0, 32'h40, 5'd4, 1'b1);
    tick;
    valid_in = 1'b0;
    tick;
    rst = 1'b1; tick; tick; rst = 1'b0;
    n_tests++;
    if ({valid_out, regwrite_out, zero, overflow, aluresult, pc_branch, wreg_out, stall_out} !== '0) begin
      n_fail++; $display("FAIL reset_mid_mul: got v=%b res=%h pc=%h so=%b expected all 0",
                         valid_out, aluresult, pc_branch, stall_out);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      n_tests++;
      if (valid_out !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_late_result: got valid_out=%b expected 0", valid_out);
      end
    end
  endtask

  task automatic test_add;
    drive(1'b1, ALUOP_ADD, 32'd5, 32'hDEAD, 32'd7, 1'b0, 32'h100, 5'd3, 1'b1);
    tick;
    valid_in = 1'b0;
    n_tests++;
    if ({valid_out, regwrite_out, zero, overflow, aluresult, pc_branch, wreg_out} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 32'd12, 32'h11C, 5'd3}) begin
      n_fail++; $display("FAIL add_basic: got v=%b rw=%b z=%b o=%b res=%h pc=%h wr=%0d expected 1 1 0 0 0000000c 0000011c 3",
                         valid_out, regwrite_out, zero, overflow, aluresult, pc_branch, wreg_out);
    end
  endtask

  task automatic test_mul_overflow;
    int n;
    drive(1'b1, ALUOP_MUL, 32'h00010000, 32'h00010000, 32'd0, 1'b1, 32'h200, 5'd6, 1'b1);
    tick;
    valid_in = 1'b0;
    n = 0;
    while (stall_out === 1'b1 && n < 20) begin
      tick;
      n++;
    end
    n_tests++;
    if (n != 3) begin
      n_fail++; $display("FAIL mul_stall_cycles: got %0d expected 3", n);
    end
    n_tests++;
    if ({valid_out, regwrite_out, zero, overflow, aluresult, pc_branch, wreg_out} !==
        {1'b1, 1'b1, 1'b1, 1'b1, 32'd0, 32'h200, 5'd6}) begin
      n_fail++; $display("FAIL mul_overflow: got v=%b rw=%b z=%b o=%b res=%h pc=%h wr=%0d expected 1 1 1 1 0 200 6",
                         valid_out, regwrite_out, zero, overflow, aluresult, pc_branch, wreg_out);
    end
  endtask

  task automatic test_mul_stall_done;
    drive(1'b1, ALUOP_MUL, 32'hFFFFFFFD, 32'd0, 32'd4, 1'b0, 32'h300, 5'd9, 1'b1);
    tick;
    valid_in = 1'b0;
    stall_in = 1'b1;
    repeat (5) tick;
    n_tests++;
    if ({stall_out, valid_out} !== 2'b10) begin
      n_fail++; $display("FAIL mul_done_hold: got stall_out=%b valid_out=%b expected 1 0", stall_out, valid_out);
    end
    stall_in = 1'b0;
    #1;
    n_tests++;
    if (stall_out !== 1'b1) begin
      n_fail++; $display("FAIL mul_done_state: got stall_out=%b expected 1", stall_out);
    end
    tick;
    n_tests++;
    if ({valid_out, zero, overflow, aluresult, pc_branch, stall_out} !==
        {1'b1, 1'b0, 1'b0, 32'hFFFFFFF4, 32'h310, 1'b0}) begin
      n_fail++; $display("FAIL mul_after_release: got v=%b z=%b o=%b res=%h pc=%h so=%b expected 1 0 0 fffffff4 310 0",
                         valid_out, zero, overflow, aluresult, pc_branch, stall_out);
    end
  endtask

  task automatic test_flush;
    drive(1'b1, ALUOP_ADD, 32'd1, 0, 32'd1, 1'b0, 0, 5'd1, 1'b1);
    tick;
    flush = 1'b1;
    drive(1'b1, ALUOP_ADD, 32'd2, 0, 32'd2, 1'b0, 0, 5'd2, 1'b1);
    tick;
    flush = 1'b0;
    n_tests++;
    if ({valid_out, regwrite_out} !== 2'b00) begin
      n_fail++; $display("FAIL flush_alu: got v=%b rw=%b expected 0 0", valid_out, regwrite_out);
    end
    drive(1'b1, ALUOP_MUL, 32'd6, 32'd7, 0, 1'b1, 0, 5'd5, 1'b1);
    tick;
    valid_in = 1'b0;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    n_tests++;
    if ({valid_out, regwrite_out, stall_out} !== 3'b000) begin
      n_fail++; $display("FAIL flush_mul: got v=%b rw=%b so=%b expected 0 0 0", valid_out, regwrite_out, stall_out);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      n_tests++;
      if (valid_out !== 1'b0) begin
        n_fail++; $display("FAIL flush_no_late_result: got valid_out=%b expected 0", valid_out);
      end
    end
  endtask

  task automatic test_stall_in;
    drive(1'b1, ALUOP_XOR, 32'hF0F0_1234, 32'h0FF0_0000, 0, 1'b1, 32'h80, 5'd11, 1'b1);
    tick;
    stall_in = 1'b1;
    drive(1'b1, ALUOP_OR, 32'h1, 32'h2, 32'h5, 1'b1, 32'h90, 5'd12, 1'b0);
    tick; tick;
    n_tests++;
    if ({stall_out, valid_out, regwrite_out, aluresult, pc_branch, wreg_out} !==
        {1'b1, 1'b1, 1'b1, 32'hFF00_1234, 32'h80, 5'd11}) begin
      n_fail++; $display("FAIL stall_in_hold: got so=%b v=%b rw=%b res=%h pc=%h wr=%0d expected 1 1 1 ff001234 80 11",
                         stall_out, valid_out, regwrite_out, aluresult, pc_branch, wreg_out);
    end
    stall_in = 1'b0;
    tick;
    valid_in = 1'b0;
    n_tests++;
    if ({valid_out, regwrite_out, aluresult, pc_branch} !== {1'b1, 1'b0, 32'h3, 32'hA4}) begin
      n_fail++; $display("FAIL stall_in_release: got v=%b rw=%b res=%h pc=%h expected 1 0 3 a4",
                         valid_out, regwrite_out, aluresult, pc_branch);
    end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, ALUOP_SUB, 32'd3, 32'd3, 32'd99, 1'b1, 0, 5'd2, 1'b1);
    tick;
    n_tests++;
    if ({zero, valid_out, aluresult} !== {1'b1, 1'b1, 32'd0}) begin
      n_fail++; $display("FAIL sub_zero: got z=%b v=%b res=%h expected 1 1 0", zero, valid_out, aluresult);
    end
    drive(1'b0, ALUOP_ADD, 32'd50, 0, 32'd50, 1'b0, 0, 5'd0, 1'b1);
    tick;
    n_tests++;
    if ({valid_out, regwrite_out, aluresult, zero} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
      n_fail++; $display("FAIL bubble_after_sub: got v=%b rw=%b res=%h z=%b expected 0 0 0 1",
                         valid_out, regwrite_out, aluresult, zero);
    end
    drive(1'b1, ALUOP_ADD, 32'd7, 32'd9, 0, 1'b1, 0, 5'd8, 1'b1);
    tick;
    drive(1'b1, ALUOP_SUB, 32'd7, 32'd9, 0, 1'b1, 0, 5'd9, 1'b1);
    tick;
    n_tests++;
    if ({valid_out, aluresult, wreg_out} !== {1'b1, 32'hFFFFFFFE, 5'd9}) begin
      n_fail++; $display("FAIL back_to_back: got v=%b res=%h wr=%0d expected 1 fffffffe 9", valid_out, aluresult, wreg_out);
    end
    valid_in = 1'b0;
    tick;
    n_tests++;
    if ({valid_out, regwrite_out, aluresult, wreg_out} !== {1'b0, 1'b0, 32'hFFFFFFFE, 5'd9}) begin
      n_fail++; $display("FAIL bubble_hold: got v=%b rw=%b res=%h wr=%0d expected 0 0 fffffffe 9",
                         valid_out, regwrite_out, aluresult, wreg_out);
    end
  endtask

  task automatic test_random;
    logic [4:0]  ops [11] = '{ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR, ALUOP_XOR, ALUOP_SLL,
                              ALUOP_SRL, ALUOP_SRA, ALUOP_SLT, ALUOP_SLTU, ALUOP_MUL};
    logic [4:0]  op, wr;
    logic [31:0] a, r2, imm, pc, b, last_res;
    logic        as, rw;
    exp_t        e;
    int          n;
    last_res = aluresult;
    for (int it = 0; it < 60; it++) begin
      op = ops[$urandom_range(0, 10)];
      a = $urandom; r2 = $urandom; imm = $urandom; pc = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        a  = 32'($urandom_range(0, 200)) - 32'd100;
        r2 = 32'($urandom_range(0, 200)) - 32'd100;
        imm = 32'($urandom_range(0, 200)) - 32'd100;
      end
      as = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1)); wr = 5'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        drive(1'b0, op, a, r2, imm, as, pc, wr, rw);
        tick;
        n_tests++;
        if ({valid_out, regwrite_out, aluresult} !== {1'b0, 1'b0, last_res}) begin
          n_fail++; $display("FAIL rand_bubble[%0d]: got v=%b rw=%b res=%h expected 0 0 %h",
                             it, valid_out, regwrite_out, aluresult, last_res);
        end
        continue;
      end
      b = as ? r2 : imm;
      e = model(op, a, b);
      drive(1'b1, op, a, r2, imm, as, pc, wr, rw);
      tick;
      valid_in = 1'b0;
      if (op == ALUOP_MUL) begin
        n = 0;
        while (stall_out === 1'b1 && n < 20) begin
          tick;
          n++;
        end
        n_tests++;
        if (n != 3) begin
          n_fail++; $display("FAIL rand_mul_latency[%0d]: got %0d expected 3", it, n);
        end
      end
      n_tests++;
      if ({valid_out, regwrite_out, wreg_out, pc_branch, zero, overflow, aluresult} !==
          {1'b1, rw, wr, model_pc(pc, imm), e.zero, e.ovf, e.res}) begin
        n_fail++; $display("FAIL rand_op[%0d] op=%0d a=%h b=%h: got v=%b rw=%b wr=%0d pc=%h z=%b o=%b res=%h expected 1 %b %0d %h %b %b %h",
                           it, op, a, b, valid_out, regwrite_out, wreg_out, pc_branch, zero, overflow,
                           aluresult, rw, wr, model_pc(pc, imm), e.zero, e.ovf, e.res);
      end
      last_res = e.res;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add;
    test_mul_overflow;
    test_mul_stall_done;
    test_flush;
    test_stall_in;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
